// File: rtl/net_engine_pkg.sv
// Shared definitions for the net_engine 3x3 convolution engine: register map,
// engine states, frame-length helper and the weight reset value.
package net_engine_pkg;

    localparam logic [4:0] REG_W0          = 5'd0;
    localparam logic [4:0] REG_W8          = 5'd8;
    localparam logic [4:0] REG_CTRL        = 5'd9;
    localparam logic [4:0] REG_STATUS      = 5'd10;
    localparam logic [4:0] REG_FRAME_COUNT = 5'd11;

    localparam logic signed [31:0] WEIGHT_RESET = 32'sd1;

    typedef enum logic [1:0] {
        ST_RECV,
        ST_COMPUTE,
        ST_WAIT,
        ST_SEND
    } state_t;

    // One bias word followed by three rows of (cells + 2) pixels.
    function automatic int nwords(input int cells);
        return 1 + 3 * (cells + 2);
    endfunction

endpackage

// File: rtl/net_engine_cell.sv
// Combinational 3x3 signed multiply-accumulate plus bias, wrapping at DATA_W bits.
module net_engine_cell #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32
) (
    input  logic signed [DATA_W-1:0]   bias,
    input  logic        [8:0][COEF_W-1:0] weights,
    input  logic        [8:0][DATA_W-1:0] pixels,
    output logic signed [DATA_W-1:0]   result
);

    always_comb begin
        result = bias;
        for (int i = 0; i < 9; i++) begin
            result = result + DATA_W'($signed(weights[i]) * $signed(pixels[i]));
        end
    end

endmodule

// File: rtl/net_engine.sv
// Streaming 3x3 convolution engine with AXI4-Lite weights/status and AXI4-Stream I/O.
// Define NET_ENGINE_RELU_EN to clamp negative cell results to zero.
module net_engine
    import net_engine_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 7,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_START_COUNT = 16,
    parameter int C_NET_CELL_COUNT       = 2
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic                                S_WRITE_COMPLETE,
    output logic [31:0]                         DEBUG_WRITE_POINTER,
    output logic [31:0]                         DEBUG_READ_POINTER
);

    localparam int N      = C_NET_CELL_COUNT;
    localparam int NCOL   = N + 2;
    localparam int NPIX   = 3 * NCOL;
    localparam int NW     = nwords(N);
    localparam int SC     = C_M00_AXIS_START_COUNT;
    localparam int DATA_W = 32;

    logic [8:0][DATA_W-1:0]    weights;
    logic                      awready_r, bvalid_r, arready_r, rvalid_r;
    logic [DATA_W-1:0]         rdata_r, rd_mux;
    logic [4:0]                waddr, raddr;
    logic                      wen, soft_clr;

    state_t                    state;
    logic                      s_tready, m_tvalid, write_complete, tlast_err;
    logic [31:0]               wr_ptr, rd_ptr, cnt, frame_count;
    logic signed [DATA_W-1:0]  bias;
    logic [DATA_W-1:0]         pix [NPIX];
    logic signed [DATA_W-1:0]  res [N];
    logic [8:0][DATA_W-1:0]    window;
    logic signed [DATA_W-1:0]  cell_sum;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], s00_axis_tstrb};

    function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] v);
`ifdef NET_ENGINE_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign waddr    = s00_axi_awaddr[6:2];
    assign raddr    = s00_axi_araddr[6:2];
    assign wen      = awready_r && s00_axi_awvalid && s00_axi_wvalid;
    assign soft_clr = wen && (waddr == REG_CTRL) && s00_axi_wstrb[0] && s00_axi_wdata[0];

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < 9; i++) begin
            if (raddr == 5'(i)) rd_mux = weights[i];
        end
        case (raddr)
            REG_STATUS:      rd_mux = {28'd0, tlast_err, write_complete,
                                       state != ST_RECV, state == ST_RECV};
            REG_FRAME_COUNT: rd_mux = frame_count;
            default: ;
        endcase
    end

    // AXI4-Lite register slave
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            for (int i = 0; i < 9; i++) weights[i] <= WEIGHT_RESET;
        end else begin
            awready_r <= s00_axi_awvalid && s00_axi_wvalid && !bvalid_r && !awready_r;
            if (bvalid_r && s00_axi_bready) bvalid_r <= 1'b0;
            if (wen) begin
                bvalid_r <= 1'b1;
                for (int i = 0; i < 9; i++) begin
                    if (waddr == 5'(i) && waddr <= REG_W8 && waddr >= REG_W0) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s00_axi_wstrb[b]) weights[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                        end
                    end
                end
            end
            arready_r <= s00_axi_arvalid && !rvalid_r && !arready_r;
            if (s00_axi_arvalid && arready_r) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux;
            end else if (rvalid_r && s00_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // The pixel buffer shifts left one column per compute cycle, so cell j always
    // sees its window at the fixed leading positions of each row.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign window[3*r+c] = pix[r*NCOL+c];
        end
    end

    net_engine_cell #(.DATA_W(DATA_W), .COEF_W(DATA_W)) u_cell (
        .bias    (bias),
        .weights (weights),
        .pixels  (window),
        .result  (cell_sum)
    );

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn || soft_clr) begin
            state          <= ST_RECV;
            s_tready       <= 1'b1;
            m_tvalid       <= 1'b0;
            write_complete <= 1'b0;
            tlast_err      <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            bias           <= '0;
            for (int k = 0; k < NPIX; k++) pix[k] <= '0;
            for (int k = 0; k < N; k++) res[k] <= '0;
            if (!s00_axi_aresetn) frame_count <= '0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (s00_axis_tvalid && s_tready) begin
                        if (wr_ptr == '0) begin
                            bias <= $signed(s00_axis_tdata);
                        end else begin
                            for (int k = 0; k < NPIX-1; k++) pix[k] <= pix[k+1];
                            pix[NPIX-1] <= s00_axis_tdata;
                        end
                        if (wr_ptr == 32'(NW - 1)) begin
                            state          <= ST_COMPUTE;
                            s_tready       <= 1'b0;
                            write_complete <= 1'b1;
                            wr_ptr         <= wr_ptr + 32'd1;
                            cnt            <= '0;
                        end else if (s00_axis_tlast) begin
                            wr_ptr    <= '0;
                            tlast_err <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 32'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    for (int k = 0; k < NPIX-1; k++) pix[k] <= pix[k+1];
                    for (int k = 0; k < N-1; k++) res[k] <= res[k+1];
                    res[N-1] <= relu_clamp(cell_sum);
                    cnt      <= cnt + 32'd1;
                    if (cnt == 32'(N - 1)) begin
                        cnt <= '0;
                        if (SC == 0) begin
                            state    <= ST_SEND;
                            m_tvalid <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 32'(SC - 1)) begin
                        cnt      <= '0;
                        state    <= ST_SEND;
                        m_tvalid <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_SEND: begin
                    if (m_tvalid && m00_axis_tready) begin
                        for (int k = 0; k < N-1; k++) res[k] <= res[k+1];
                        res[N-1] <= '0;
                        if (rd_ptr == 32'(N - 1)) begin
                            state          <= ST_RECV;
                            s_tready       <= 1'b1;
                            m_tvalid       <= 1'b0;
                            write_complete <= 1'b0;
                            rd_ptr         <= '0;
                            wr_ptr         <= '0;
                            frame_count    <= frame_count + 32'd1;
                        end else begin
                            rd_ptr <= rd_ptr + 32'd1;
                        end
                    end
                end
                default: state <= ST_RECV;
            endcase
        end
    end

    assign s00_axi_awready     = awready_r;
    assign s00_axi_wready      = awready_r;
    assign s00_axi_bvalid      = bvalid_r;
    assign s00_axi_bresp       = 2'b00;
    assign s00_axi_arready     = arready_r;
    assign s00_axi_rvalid      = rvalid_r;
    assign s00_axi_rdata       = rdata_r;
    assign s00_axi_rresp       = 2'b00;
    assign s00_axis_tready     = s_tready;
    assign m00_axis_tvalid     = m_tvalid;
    assign m00_axis_tdata      = m_tvalid ? res[0] : '0;
    assign m00_axis_tstrb      = {(C_M00_AXIS_TDATA_WIDTH/8){m_tvalid}};
    assign m00_axis_tlast      = m_tvalid && (rd_ptr == 32'(N - 1));
    assign S_WRITE_COMPLETE    = write_complete;
    assign DEBUG_WRITE_POINTER = wr_ptr;
    assign DEBUG_READ_POINTER  = rd_ptr;

endmodule

// File: tb/tb_net_engine.sv
// Scoreboard bench for net_engine: expected results are queued at frame issue
// and a monitor process checks every output handshake.
module tb_net_engine;

    localparam int N    = 2;
    localparam int SC   = 16;
    localparam int NCOL = N + 2;
    localparam int NW   = 1 + 3 * NCOL;

    logic        clk, rst_n;
    logic [6:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tlast, s_tvalid, s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast, m_tvalid, m_tready;
    logic        swc;
    logic [31:0] dbg_wp, dbg_rp;

    net_engine dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
        .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
        .S_WRITE_COMPLETE(swc), .DEBUG_WRITE_POINTER(dbg_wp), .DEBUG_READ_POINTER(dbg_rp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 rdy_mode = 0;
    bit                 gap_en = 0;
    int                 fc_model = 0;
    logic signed [31:0] w_model [9];
    logic signed [31:0] fr [NW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Reference: R[j] = B + sum W[3r+c] * P[r][j+c], 32-bit wrap.
    function automatic logic [31:0] model_out(input int j);
        logic signed [31:0] acc;
        acc = fr[0];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc = acc + w_model[3*r+c] * fr[1 + r*NCOL + j + c];
`ifdef NET_ENGINE_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic push_expected();
        for (int j = 0; j < N; j++) exp_q.push_back('{data: model_out(j), last: (j == N-1), idx: j});
        fc_model++;
    endtask

    task automatic load_strip(input logic [31:0] b, input int offset);
        fr[0] = b;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NCOL; c++)
                fr[1 + r*NCOL + c] = 32'(6*r + c + offset);
    endtask

    task automatic drive_frame(input int nsend, input int last_at);
        for (int w = 0; w < nsend; w++) begin
            int guard = 0;
            if (gap_en && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                s_tvalid = 1'b0;
            end
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = fr[w];
            s_tlast  = (w == last_at);
            while (!s_tready && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 3000) timeout_fail("input_tready");
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic axi_write(input int addr, input logic [31:0] d, input logic [3:0] st);
        int guard = 0;
        @(negedge clk);
        awaddr = 7'(addr); wdata = d; wstrb = st;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!awready && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeout_fail("axi_awready");
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        guard = 0;
        while (!bvalid && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeout_fail("axi_bvalid");
        check("bresp", 32'(bresp), 32'd0);
        for (int b = 0; b < 4; b++)
            if (addr / 4 < 9 && st[b]) w_model[addr/4][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic axi_read(input int addr, output logic [31:0] d);
        int guard = 0;
        @(negedge clk);
        araddr = 7'(addr); arvalid = 1'b1;
        while (!arready && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeout_fail("axi_arready");
        @(negedge clk);
        arvalid = 1'b0;
        guard = 0;
        while (!rvalid && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeout_fail("axi_rvalid");
        d = rdata;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_tvalid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) timeout_fail("output_drain");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_m_tdata"}, m_tdata, 32'd0);
        check({tag, "_m_tstrb"}, 32'(m_tstrb), 32'd0);
        check({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_swc"}, 32'(swc), 32'd0);
        check({tag, "_wp"}, dbg_wp, 32'd0);
        check({tag, "_rp"}, dbg_rp, 32'd0);
        check({tag, "_axi_valids"}, {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check({tag, "_resp"}, {28'd0, bresp, rresp}, 32'd0);
    endtask

    // Output monitor: picks tready for the coming edge, then scores the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
            if (rst_n && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=0x%08h expected=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_tdata, e.data);
                    check("out_last", 32'(m_tlast), 32'(e.last));
                    check("out_rdptr", dbg_rp, 32'(e.idx));
                    check("out_tstrb", 32'(m_tstrb), 32'hF);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 9; i++) w_model[i] = 32'sd1;

        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");
        check("after_reset_s_tready", 32'(s_tready), 32'd1);
        axi_read(0, rd);
        check("w0_reset", rd, 32'd1);
        axi_read(32'h28, rd);
        check("status_reset", rd, 32'h1);

        // Default weights, first strip, with latency measurement.
        load_strip(32'd0, 0);
        push_expected();
        drive_frame(NW, NW - 1);
        lat = 1;
        while (!m_tvalid && lat < 300) begin @(negedge clk); lat++; end
        check("latency", 32'(lat - 1), 32'(N + SC));
        check("swc_in_send", 32'(swc), 32'd1);
        check("s_tready_in_send", 32'(s_tready), 32'd0);
        wait_drain();
        check("swc_after_send", 32'(swc), 32'd0);
        check("s_tready_after_send", 32'(s_tready), 32'd1);

        load_strip(32'd0, 2);
        push_expected();
        drive_frame(NW, NW - 1);
        wait_drain();
        axi_read(32'h2C, rd);
        check("frame_count_2", rd, 32'(fc_model));

        // Centre-only kernel; W4 loaded through a partial byte strobe.
        for (int i = 0; i < 9; i++) axi_write(4*i, 32'd0, 4'hF);
        axi_write(16, 32'hFFFFFF02, 4'b0001);
        axi_read(16, rd);
        check("w4_strobe", rd, w_model[4]);
        load_strip(32'd5, 0);
        push_expected();
        drive_frame(NW, -1);
        wait_drain();

        // Backpressure: output must hold while tready is low.
        for (int i = 0; i < 9; i++) axi_write(4*i, 32'd1, 4'hF);
        rdy_mode = 2;
        load_strip(32'd0, 0);
        push_expected();
        drive_frame(NW, NW - 1);
        lat = 0;
        while (!m_tvalid && lat < 300) begin @(negedge clk); lat++; end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("hold_tdata", m_tdata, exp_q[0].data);
            check("hold_tvalid", 32'(m_tvalid), 32'd1);
            check("hold_s_tready", 32'(s_tready), 32'd0);
        end
        rdy_mode = 0;
        wait_drain();

        // Early tlast on word 5 drops the frame and sets the sticky error.
        load_strip(32'd0, 0);
        drive_frame(6, 5);
        @(negedge clk);
        check("early_wp", dbg_wp, 32'd0);
        axi_read(32'h28, rd);
        check("status_early", rd, 32'h9);
        push_expected();
        drive_frame(NW, NW - 1);
        wait_drain();
        axi_write(32'h24, 32'h1, 4'hF);
        axi_read(32'h28, rd);
        check("status_soft_clear", rd, 32'h1);
        axi_read(32'h24, rd);
        check("ctrl_reads_zero", rd, 32'd0);
        axi_read(32'h2C, rd);
        check("frame_count_kept", rd, 32'(fc_model));
        axi_write(32'h40, 32'hDEADBEEF, 4'hF);
        axi_read(32'h40, rd);
        check("unmapped_zero", rd, 32'd0);

        // Randomized frames, weights and output backpressure.
        gap_en = 1;
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) begin
            if (f % 3 == 0) begin
                int k;
                wait_drain();
                for (int i = 0; i < 9; i++)
                    axi_write(4*i, 32'($urandom_range(0, 20)) - 32'd10, 4'($urandom_range(1, 15)));
                k = $urandom_range(0, 8);
                axi_read(4*k, rd);
                check("w_readback", rd, w_model[k]);
            end
            for (int k = 0; k < NW; k++)
                fr[k] = (f % 2 == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
            push_expected();
            drive_frame(NW, ($urandom_range(0, 1) == 1) ? NW - 1 : -1);
        end
        wait_drain();
        gap_en = 0;
        rdy_mode = 0;
        axi_read(32'h2C, rd);
        check("frame_count_rand", rd, 32'(fc_model));

        // Negative kernel, then reset in the middle of SEND.
        for (int i = 0; i < 9; i++) axi_write(4*i, 32'hFFFFFFFF, 4'hF);
        load_strip(32'd0, 0);
        push_expected();
        drive_frame(NW, NW - 1);
        wait_drain();
        rdy_mode = 2;
        push_expected();
        drive_frame(NW, NW - 1);
        lat = 0;
        while (!m_tvalid && lat < 300) begin @(negedge clk); lat++; end
        check("send_before_reset", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check_idle_outputs("mid_send_reset");
        check("mid_send_reset_s_tready", 32'(s_tready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) w_model[i] = 32'sd1;
        fc_model = 0;
        rdy_mode = 0;
        @(negedge clk);
        axi_read(0, rd);
        check("w0_after_reset", rd, 32'd1);
        axi_read(32'h2C, rd);
        check("frame_count_after_reset", rd, 32'(fc_model));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
